// File: rtl/action_issue_ctrl_pkg.sv
// Shared widths and helpers for the action issue scheduler.
// Holds the RMT bus widths used by action_engine and the lookup.
package action_issue_ctrl_pkg;

    localparam int unsigned PHV_LEN_DEF = 1124;  // 48*8 + 32*8 + 16*8 + 5*20 + 256
    localparam int unsigned ACT_LEN_DEF = 25;
    localparam int unsigned ACT_NUM_DEF = 25;
    localparam int unsigned DEPTH_DEF   = 8;
    localparam int unsigned CREDITS_DEF = 4;

    // Width of a counter that must hold values 0..n inclusive (n a power of 2 or not).
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/action_issue_ctrl_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head, occupancy count and
// synchronous clear. Pointers carry one extra wrap bit so full/empty are
// distinguished without a separate flag.
module action_issue_ctrl_sync_fifo
    import action_issue_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_rd;
    logic             do_wr;

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a write to a full FIFO is taken.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    // Pointer update; clear wins over any write or read in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/action_issue_ctrl.sv
// Issue scheduler in front of a stage's action engine. Buffers PHVs and action
// words independently, pairs them positionally and issues one pair per cycle
// when a downstream credit is available. Provides PHV backpressure, sticky
// overflow/credit error flags and an issued-pair counter.
module action_issue_ctrl
    import action_issue_ctrl_pkg::*;
#(
    parameter int unsigned STAGE   = 0,
    parameter int unsigned PHV_LEN = PHV_LEN_DEF,
    parameter int unsigned ACT_LEN = ACT_LEN_DEF,
    parameter int unsigned ACT_NUM = ACT_NUM_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned CREDITS = CREDITS_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [PHV_LEN-1:0]         phv_in,
    input  logic                       phv_valid_in,
    output logic                       phv_ready_out,
    input  logic [ACT_LEN*ACT_NUM-1:0] action_in,
    input  logic                       action_valid_in,
    input  logic                       flush,
    input  logic                       credit_return,
    output logic [PHV_LEN-1:0]         phv_out,
    output logic                       phv_valid_out,
    output logic [ACT_LEN*ACT_NUM-1:0] action_out,
    output logic                       action_valid_out,
    output logic                       phv_ovf,
    output logic                       act_ovf,
    output logic                       credit_err,
    output logic [31:0]                issue_cnt
);

    localparam int unsigned ACT_W = ACT_LEN * ACT_NUM;
    localparam int unsigned CW    = cnt_width(DEPTH);
    localparam int unsigned CRW   = cnt_width(CREDITS);
    localparam logic [CW-1:0]  READY_LIMIT = CW'(DEPTH - 2);
    localparam logic [CRW-1:0] CREDIT_MAX  = CRW'(CREDITS);

    logic [PHV_LEN-1:0] phv_head;
    logic [ACT_W-1:0]   act_head;
    logic               phv_full;
    logic               phv_empty;
    logic               act_full;
    logic               act_empty;
    logic [CW-1:0]      phv_cnt;
    logic [CW-1:0]      act_cnt;
    logic [CW-1:0]      phv_cnt_nxt;
    logic               phv_push_ok;
    logic               issue;
    logic [CRW-1:0]     credit_cnt;
    logic [CRW-1:0]     credit_nxt;
    logic               credit_full;
    logic               unused_ok;

    assign unused_ok = ^{act_cnt, (STAGE == 0)};

    action_issue_ctrl_sync_fifo #(
        .WIDTH (PHV_LEN),
        .DEPTH (DEPTH)
    ) u_phv_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (phv_valid_in && !flush),
        .wr_data (phv_in),
        .rd_en   (issue),
        .rd_data (phv_head),
        .full    (phv_full),
        .empty   (phv_empty),
        .count   (phv_cnt)
    );

    action_issue_ctrl_sync_fifo #(
        .WIDTH (ACT_W),
        .DEPTH (DEPTH)
    ) u_act_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (action_valid_in && !flush),
        .wr_data (action_in),
        .rd_en   (issue),
        .rd_data (act_head),
        .full    (act_full),
        .empty   (act_empty),
        .count   (act_cnt)
    );

    assign issue       = !phv_empty && !act_empty && (credit_cnt != '0) && !flush;
    assign credit_full = (credit_cnt == CREDIT_MAX);
    assign phv_push_ok = phv_valid_in && !flush && (!phv_full || issue);

    // Post-edge PHV occupancy, used to register the ready flag one cycle early.
    always_comb begin
        phv_cnt_nxt = phv_cnt;
        if (flush) begin
            phv_cnt_nxt = '0;
        end else begin
            if (phv_push_ok) phv_cnt_nxt = phv_cnt_nxt + CW'(1);
            if (issue)       phv_cnt_nxt = phv_cnt_nxt - CW'(1);
        end
    end

    // Credit accounting: issue consumes, return refills, saturating at CREDITS.
    always_comb begin
        credit_nxt = credit_cnt;
        if (issue && !credit_return)
            credit_nxt = credit_cnt - CRW'(1);
        else if (credit_return && !issue && !credit_full)
            credit_nxt = credit_cnt + CRW'(1);
    end

    // Credit counter and ready register; flush leaves credits alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_cnt    <= CREDIT_MAX;
            phv_ready_out <= 1'b1;
        end else begin
            credit_cnt    <= credit_nxt;
            phv_ready_out <= (phv_cnt_nxt < READY_LIMIT);
        end
    end

    // Issue register: valids pulse per pair, data holds the last issued pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_out          <= '0;
            action_out       <= '0;
            phv_valid_out    <= 1'b0;
            action_valid_out <= 1'b0;
            issue_cnt        <= '0;
        end else begin
            phv_valid_out    <= issue;
            action_valid_out <= issue;
            if (issue) begin
                phv_out    <= phv_head;
                action_out <= act_head;
                issue_cnt  <= issue_cnt + 32'd1;
            end
        end
    end

    // Sticky error flags; flush clears them and suppresses new sets that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_ovf    <= 1'b0;
            act_ovf    <= 1'b0;
            credit_err <= 1'b0;
        end else if (flush) begin
            phv_ovf    <= 1'b0;
            act_ovf    <= 1'b0;
            credit_err <= 1'b0;
        end else begin
            if (phv_valid_in && phv_full && !issue)           phv_ovf    <= 1'b1;
            if (action_valid_in && act_full && !issue)        act_ovf    <= 1'b1;
            if (credit_return && credit_full && !issue)       credit_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_action_issue_ctrl.sv
// Directed bench for action_issue_ctrl with a scoreboard of expected pairs
// and the cycle each pair should appear on the action engine interface.
module tb_action_issue_ctrl;

    localparam int unsigned PW = 32;
    localparam int unsigned AW = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] phv_in = '0;
    logic          phv_valid_in = 1'b0;
    logic          phv_ready_out;
    logic [AW-1:0] action_in = '0;
    logic          action_valid_in = 1'b0;
    logic          flush = 1'b0;
    logic          credit_return = 1'b0;
    logic [PW-1:0] phv_out;
    logic          phv_valid_out;
    logic [AW-1:0] action_out;
    logic          action_valid_out;
    logic          phv_ovf;
    logic          act_ovf;
    logic          credit_err;
    logic [31:0]   issue_cnt;

    action_issue_ctrl #(
        .STAGE   (0),
        .PHV_LEN (PW),
        .ACT_LEN (5),
        .ACT_NUM (4),
        .DEPTH   (8),
        .CREDITS (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .phv_in           (phv_in),
        .phv_valid_in     (phv_valid_in),
        .phv_ready_out    (phv_ready_out),
        .action_in        (action_in),
        .action_valid_in  (action_valid_in),
        .flush            (flush),
        .credit_return    (credit_return),
        .phv_out          (phv_out),
        .phv_valid_out    (phv_valid_out),
        .action_out       (action_out),
        .action_valid_out (action_valid_out),
        .phv_ovf          (phv_ovf),
        .act_ovf          (act_ovf),
        .credit_err       (credit_err),
        .issue_cnt        (issue_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PW-1:0] phv;
        logic [AW-1:0] act;
        int            at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [PW-1:0] pd(input int k);
        return 32'hA000_0000 + PW'(k);
    endfunction

    function automatic logic [AW-1:0] ad(input int k);
        return 20'hB0000 + AW'(k);
    endfunction

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
        end
    endtask

    task automatic expect_pair(input int k, input int at);
        exp_t e;
        e.phv = pd(k);
        e.act = ad(k);
        e.at  = at;
        sb.push_back(e);
    endtask

    // One cycle of stimulus, applied just after a rising edge.
    task automatic drive(input bit pv, input int pk, input bit av, input int ak,
                         input bit cr, input bit fl);
        phv_valid_in    = pv;
        phv_in          = pd(pk);
        action_valid_in = av;
        action_in       = ad(ak);
        credit_return   = cr;
        flush           = fl;
        @(posedge clk);
        #1;
        phv_valid_in    = 1'b0;
        action_valid_in = 1'b0;
        credit_return   = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every presented pair must match the scoreboard head in data and cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (action_valid_out !== phv_valid_out) begin
                errors++;
                $display("FAIL valid_align: action_valid_out=%0b phv_valid_out=%0b", action_valid_out, phv_valid_out);
            end
            if (phv_valid_out === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue: got phv %0h act %0h at cycle %0d, expected none", phv_out, action_out, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (phv_out !== e.phv || action_out !== e.act || (e.at >= 0 && cyc != e.at)) begin
                        errors++;
                        $display("FAIL pair: got phv %0h act %0h cycle %0d, expected phv %0h act %0h cycle %0d",
                                 phv_out, action_out, cyc, e.phv, e.act, e.at);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", phv_ready_out, 1);
        chk("rst_valid", {phv_valid_out, action_valid_out}, 0);
        chk("rst_data", {phv_out, action_out}, 0);
        chk("rst_flags", {phv_ovf, act_ovf, credit_err}, 0);
        chk("rst_issue_cnt", issue_cnt, 0);
        rst_n = 1'b1;
        idle(1);

        // PHV first, action three cycles later: issue one cycle after the action
        drive(1, 0, 0, 0, 0, 0);
        idle(2);
        expect_pair(0, cyc + 2);
        drive(0, 0, 1, 0, 0, 0);
        idle(2);
        chk("t1_issue_cnt", issue_cnt, 1);
        drive(0, 0, 0, 0, 1, 0);

        // Three PHVs then three actions: three back-to-back issues
        for (int k = 1; k <= 3; k++) drive(1, k, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            expect_pair(k, cyc + 2);
            drive(0, 0, 1, k, 0, 0);
        end
        idle(2);
        chk("t2_issue_cnt", issue_cnt, 4);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1, 0);

        // Six pairs, four credits: stall after four, each return releases one
        for (int k = 10; k < 16; k++) begin
            if (k < 14) expect_pair(k, cyc + 2);
            drive(1, k, 1, k, 0, 0);
        end
        idle(3);
        chk("t3_stall_cnt", issue_cnt, 8);
        expect_pair(14, cyc + 2);
        drive(0, 0, 0, 0, 1, 0);
        idle(2);
        expect_pair(15, cyc + 2);
        drive(0, 0, 0, 0, 1, 0);
        idle(2);
        chk("t3_issue_cnt", issue_cnt, 10);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0);

        // Fill the PHV FIFO: ready drops at six entries, the ninth PHV overflows
        for (int k = 20; k < 29; k++) begin
            drive(1, k, 0, 0, 0, 0);
            chk($sformatf("t4_ready_%0d", k - 19), phv_ready_out, (k - 19 < 6) ? 1 : 0);
            chk($sformatf("t4_ovf_%0d", k - 19), phv_ovf, (k == 28) ? 1 : 0);
        end
        for (int k = 20; k < 24; k++) begin
            expect_pair(k, cyc + 2);
            drive(0, 0, 1, k, 0, 0);
        end
        idle(1);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0);
        for (int k = 24; k < 28; k++) begin
            expect_pair(k, cyc + 2);
            drive(0, 0, 1, k, 0, 0);
        end
        idle(2);
        chk("t4_issue_cnt", issue_cnt, 18);
        chk("t4_ready_back", phv_ready_out, 1);
        chk("t4_ovf_sticky", {phv_ovf, act_ovf}, 2'b10);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0);

        // Credit return at full credit sets credit_err; flush clears all sticky flags
        drive(0, 0, 0, 0, 1, 0);
        chk("t5_credit_err", credit_err, 1);
        drive(0, 0, 0, 0, 0, 1);
        chk("t5_flush_flags", {phv_ovf, act_ovf, credit_err}, 0);
        for (int k = 30; k < 35; k++) begin
            if (k < 34) expect_pair(k, cyc + 2);
            drive(1, k, 1, k, 0, 0);
        end
        idle(3);
        chk("t5_saturated_cnt", issue_cnt, 22);
        drive(1, 40, 0, 0, 0, 1);
        chk("t5_flush_valid", phv_valid_out, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 1, 41, 0, 0);
        idle(2);
        chk("t5_after_flush_cnt", issue_cnt, 22);
        drive(0, 0, 0, 0, 0, 1);

        // Asynchronous reset with two pairs buffered
        for (int k = 50; k < 56; k++) begin
            if (k < 54) expect_pair(k, cyc + 2);
            drive(1, k, 1, k, 0, 0);
        end
        idle(1);
        chk("t6_pre_data", phv_out, pd(53));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {phv_valid_out, action_valid_out}, 0);
        chk("t6_rst_ready", phv_ready_out, 1);
        chk("t6_rst_data", {phv_out, action_out}, 0);
        chk("t6_rst_issue_cnt", issue_cnt, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(4);
        chk("t6_no_issue", issue_cnt, 0);
        expect_pair(60, cyc + 2);
        drive(1, 60, 1, 60, 0, 0);
        idle(2);
        chk("t6_post_issue_cnt", issue_cnt, 1);

        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
